// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: serialises loader, toggle-engine and display access to the
// single-port 32x32 board RAM, with a lock for atomic read-modify-write.
module board_ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            req_we,
  input  logic [2:0]            req_lock,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W-1:0]     ram_data,
  output logic                  ram_wren,
  input  logic [DATA_W-1:0]     ram_q,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DATA, WR_ISSUE} state_t;
  state_t state_q, state_d;
  logic [1:0] win, win_q, win_d, owner_q, owner_d;
  logic lock_q, lock_d, ptr_q, ptr_d, acc, ram_wren_q, ram_wren_d;
  logic [2:0] elig, gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  // ptr_q = 0 prefers requester 1, ptr_q = 1 prefers requester 2
  always_comb begin
    elig = lock_q ? (req & (3'b001 << owner_q)) : req;
    win = elig[0] ? 2'd0 : (elig[1] && (!elig[2] || !ptr_q)) ? 2'd1 : 2'd2;
    acc = (state_q == IDLE) && |elig;
    state_d = acc ? (req_we[win] ? WR_ISSUE : RD_ISSUE) : (state_q == RD_ISSUE) ? RD_DATA : IDLE;
    win_d = acc ? win : win_q;
    owner_d = acc ? win : owner_q;
    lock_d = acc ? req_lock[win] : lock_q;
    ptr_d = (acc && win != 2'd0) ? (win == 2'd1) : ptr_q;
    ram_address_d = acc ? req_addr[win*ADDR_W +: ADDR_W] : ram_address_q;
    ram_data_d = (acc && req_we[win]) ? req_wdata[win*DATA_W +: DATA_W] : ram_data_q;
    ram_wren_d = acc && req_we[win];
    gnt_d = acc ? (3'b001 << win) : 3'b000;
    rvalid_d = (state_q == RD_ISSUE) ? (3'b001 << win_q) : 3'b000;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      win_q <= 2'd0;
      owner_q <= 2'd0;
      lock_q <= 1'b0;
      ptr_q <= 1'b0;
      ram_address_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      gnt_q <= 3'b000;
      rvalid_q <= 3'b000;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      owner_q <= owner_d;
      lock_q <= lock_d;
      ptr_q <= ptr_d;
      ram_address_q <= ram_address_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
      gnt_q <= gnt_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign gnt = gnt_q;
  assign rvalid = rvalid_q;
  assign rdata = ram_q;
  assign ram_address = ram_address_q;
  assign ram_data = ram_data_q;
  assign ram_wren = ram_wren_q;
  assign busy = (state_q != IDLE) || lock_q;
endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb_board_ram_arbiter: table-driven and scoreboard bench for board_ram_arbiter
// with a behavioural one-cycle registered-read RAM.
module tb_board_ram_arbiter;
  logic clk = 0, reset = 1;
  logic [2:0] req = 0, req_we = 0, req_lock = 0;
  logic [14:0] req_addr = 0;
  logic [95:0] req_wdata = 0;
  logic [2:0] gnt, rvalid;
  logic [31:0] rdata, ram_data, ram_q = 0;
  logic [4:0] ram_address;
  logic ram_wren, busy;
  logic [31:0] mem [32];
  logic [31:0] mem_m [32];
  int checks = 0, errors = 0, cyc = 0, rv_due = -1;
  typedef struct {logic [1:0] idx; logic we; logic [4:0] addr; logic [31:0] data;} exp_t;
  typedef struct {logic [1:0] idx; logic we; logic [4:0] addr; logic [31:0] wdata; logic [31:0] rexp;} vec_t;
  exp_t gq[$], rq[$];
  vec_t vecs[9];

  board_ram_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (|gnt) begin
        if (gq.size() == 0) chk("gnt_unexpected", {29'd0, gnt}, 32'd0);
        else begin
          e = gq.pop_front();
          chk("gnt_onehot", {29'd0, gnt}, {29'd0, 3'b001 << e.idx});
          chk("gnt_wren", {31'd0, ram_wren}, {31'd0, e.we});
          chk("gnt_addr", {27'd0, ram_address}, {27'd0, e.addr});
          if (e.we) chk("gnt_wdata", ram_data, e.data);
          else rv_due = cyc + 1;
        end
      end else if (ram_wren) chk("wren_without_gnt", {31'd0, ram_wren}, 32'd0);
      if (|rvalid) begin
        if (rq.size() == 0) chk("rvalid_unexpected", {29'd0, rvalid}, 32'd0);
        else begin
          e = rq.pop_front();
          chk("rvalid_onehot", {29'd0, rvalid}, {29'd0, 3'b001 << e.idx});
          chk("rdata", rdata, e.data);
          chk("rvalid_latency", cyc, rv_due);
        end
      end
    end
  end

  task automatic push(input int i, input logic we, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.idx = 2'(i); e.we = we; e.addr = a; e.data = d;
    gq.push_back(e);
    if (we) mem_m[a] = d;
    else rq.push_back(e);
  endtask

  task automatic drive(input int i, input logic we, input logic lk, input logic [4:0] a, input logic [31:0] d);
    req[i] = 1'b1; req_we[i] = we; req_lock[i] = lk;
    req_addr[i*5 +: 5] = a; req_wdata[i*32 +: 32] = d;
  endtask

  task automatic wait_gnt(input int i, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt[i] && n < 200);
    if (!gnt[i]) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: requester %0d got no gnt within %0d cycles", i, n);
    end
  endtask

  // one isolated transaction issued from an idle arbiter
  task automatic txn(input int i, input logic we, input logic lk, input logic [4:0] a, input logic [31:0] d);
    int n;
    push(i, we, a, d);
    drive(i, we, lk, a, d);
    wait_gnt(i, n);
    chk("gnt_latency", n, 2);
    chk("busy_active", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 req[i] = 1'b0;
    @(posedge clk); #1 chk("busy_after", {31'd0, busy}, {31'd0, lk});
  endtask

  task automatic do_reset;
    reset = 1; req = 0; req_lock = 0; req_we = 0;
    @(posedge clk); #1 reset = 0;
  endtask

  initial begin
    #500000 $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'h1111_1111 * i;
      mem_m[i] = 32'h1111_1111 * i;
    end
    mem[7] = 32'hDEADBEEF;
    mem_m[7] = 32'hDEADBEEF;
    vecs[0] = '{2'd2, 1'b0, 5'd7,  32'h0,         32'hDEADBEEF};
    vecs[1] = '{2'd0, 1'b1, 5'd31, 32'h0000_0001, 32'h0};
    vecs[2] = '{2'd1, 1'b0, 5'd31, 32'h0,         32'h0000_0001};
    vecs[3] = '{2'd0, 1'b1, 5'd0,  32'hA5A5_A5A5, 32'h0};
    vecs[4] = '{2'd2, 1'b0, 5'd0,  32'h0,         32'hA5A5_A5A5};
    vecs[5] = '{2'd1, 1'b1, 5'd15, 32'hCAFE_F00D, 32'h0};
    vecs[6] = '{2'd0, 1'b0, 5'd15, 32'h0,         32'hCAFE_F00D};
    vecs[7] = '{2'd2, 1'b1, 5'd7,  32'h1234_5678, 32'h0};
    vecs[8] = '{2'd1, 1'b0, 5'd7,  32'h0,         32'h1234_5678};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_rvalid", {29'd0, rvalid}, 32'd0);
    chk("rst_addr", {27'd0, ram_address}, 32'd0);
    chk("rst_data", ram_data, 32'd0);
    chk("rst_wren", {31'd0, ram_wren}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 0;
    @(posedge clk); #1;
    foreach (vecs[k])
      txn(vecs[k].idx, vecs[k].we, 1'b0, vecs[k].addr, vecs[k].we ? vecs[k].wdata : vecs[k].rexp);
    // fixed priority for 0, then 1/2 alternation once 0 lets go
    do_reset();
    push(0, 0, 1, mem_m[1]); push(0, 0, 1, mem_m[1]);
    push(1, 0, 2, mem_m[2]); push(2, 0, 3, mem_m[3]);
    push(1, 0, 2, mem_m[2]); push(2, 0, 3, mem_m[3]);
    drive(0, 0, 0, 1, 0); drive(1, 0, 0, 2, 0); drive(2, 0, 0, 3, 0);
    wait_gnt(0, n); wait_gnt(0, n);
    @(posedge clk); #1 req[0] = 0;
    wait_gnt(1, n); wait_gnt(2, n); wait_gnt(1, n); wait_gnt(2, n);
    @(posedge clk); #1 req = 0;
    repeat (3) @(posedge clk);
    #1 chk("arb_drained", gq.size(), 0);
    // locked read-modify-write by requester 1 blocks 0 and 2
    push(1, 0, 4, mem_m[4]);
    drive(1, 0, 1, 4, 0);
    wait_gnt(1, n);
    @(posedge clk); #1 req[1] = 0;
    drive(0, 0, 0, 5, 0); drive(2, 0, 0, 6, 0);
    repeat (8) @(posedge clk);
    #1 chk("lock_busy", {31'd0, busy}, 32'd1);
    push(1, 1, 4, 32'h4444_0000); push(0, 0, 5, mem_m[5]); push(2, 0, 6, mem_m[6]);
    drive(1, 1, 0, 4, 32'h4444_0000);
    wait_gnt(1, n);
    @(posedge clk); #1 req[1] = 0;
    wait_gnt(0, n);
    chk("unlock_to_gnt0", n, 2);
    @(posedge clk); #1 req[0] = 0;
    wait_gnt(2, n);
    @(posedge clk); #1 req[2] = 0;
    repeat (2) @(posedge clk);
    #1 txn(0, 0, 0, 4, 32'h4444_0000);
    // reset during RD_ISSUE while requester 1 holds the lock
    txn(1, 0, 1, 9, mem_m[9]);
    drive(1, 0, 1, 10, 0);
    @(posedge clk); #1 reset = 1;
    #1;
    chk("rdrst_gnt", {29'd0, gnt}, 32'd0);
    chk("rdrst_rvalid", {29'd0, rvalid}, 32'd0);
    chk("rdrst_wren", {31'd0, ram_wren}, 32'd0);
    chk("rdrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset = 0; req = 0;
    txn(2, 0, 0, 12, mem_m[12]);
    // reset during WR_ISSUE discards the write
    drive(0, 1, 0, 20, 32'hBAD0_BAD0);
    @(posedge clk); #1 chk("wr_issue_wren", {31'd0, ram_wren}, 32'd1);
    reset = 1;
    #1;
    chk("wrrst_wren", {31'd0, ram_wren}, 32'd0);
    chk("wrrst_gnt", {29'd0, gnt}, 32'd0);
    @(posedge clk); #1 reset = 0; req = 0;
    txn(2, 0, 0, 20, mem_m[20]);
    repeat (3) @(posedge clk);
    #1;
    chk("gq_drained", gq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
